sr_latch_driver: RTL and testbench

- Synchronous initiator for a cross-coupled NAND SR latch. It converts single-cycle set/reset commands into clean active-low sbar/rbar pulses of controlled width.
- It enforces an inactive gap between pulses and never drives sbar and rbar low together, which is the forbidden NAND-latch input.
- It reads the latch Q back through a synchronizer to confirm each command.
- Sits between control logic and any discrete SR latch instance.

---
 rtl/sr_drv_pkg.sv | 24 ++
 rtl/sync2.sv | 22 ++
 rtl/sr_latch_driver.sv | 128 ++++++++++++
 tb/tb_sr_latch_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch driver: FSM encoding, command polarity
// and the counter sizing helper.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } drv_state_e;

    localparam logic CMD_SET   = 1'b1;
    localparam logic CMD_RESET = 1'b0;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous latch readback.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives active-low set/reset pulses into a cross-coupled NAND SR latch and
// confirms each command by watching the synchronized latch output.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command, both latch inputs high
// PULSE | target line held low for PULSE_W cycles
// GAP   | both lines high for GAP_W cycles so the latch settles
// CHECK | compare synchronized Q with target, up to TIMEOUT cycles
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic sbar,
    output logic rbar,
    input  logic q_in,
    output logic done,
    output logic err,
    output logic state_q
);

    localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, TIMEOUT) + 1);

    drv_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             target;
    logic             q_sync;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (q_sync)
    );

    // Sequencer: the phase counter reloads on every state entry and counts
    // down to zero, so it never wraps. Outputs are updated one edge ahead of
    // the state they belong to, which keeps every output registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            target    <= CMD_RESET;
            cmd_ready <= 1'b0;
            sbar      <= 1'b1;
            rbar      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            state_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    sbar      <= 1'b1;
                    rbar      <= 1'b1;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        target    <= cmd_set;
                        cmd_ready <= 1'b0;
                        cnt       <= CNT_W'(PULSE_W);
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt != '0) begin
                        // Only the target line ever goes low, so the
                        // forbidden both-low input cannot occur.
                        if (target == CMD_SET) begin
                            sbar <= 1'b0;
                            rbar <= 1'b1;
                        end else begin
                            sbar <= 1'b1;
                            rbar <= 1'b0;
                        end
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        sbar  <= 1'b1;
                        rbar  <= 1'b1;
                        cnt   <= CNT_W'(GAP_W - 1);
                        state <= GAP;
                    end
                end
                GAP: begin
                    sbar <= 1'b1;
                    rbar <= 1'b1;
                    if (cnt == '0) begin
                        cnt   <= CNT_W'(TIMEOUT - 1);
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    sbar <= 1'b1;
                    rbar <= 1'b1;
                    if (q_sync == target) begin
                        done      <= 1'b1;
                        state_q   <= target;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == '0) begin
                        err       <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    sbar      <= 1'b1;
                    rbar      <= 1'b1;
                    cmd_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural NAND latch.
module tb_sr_latch_driver;

    localparam int PULSE_W = 2;
    localparam int GAP_W   = 1;
    localparam int TIMEOUT = 8;
    localparam int HIST    = 4096;

    logic clk = 1'b0;
    logic reset, cmd_valid, cmd_set;
    logic cmd_ready, sbar, rbar, q_in, done, err, state_q;
    logic lq = 1'b0;
    logic tie0 = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    sr_latch_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_set   (cmd_set),
        .cmd_ready (cmd_ready),
        .sbar      (sbar),
        .rbar      (rbar),
        .q_in      (q_in),
        .done      (done),
        .err       (err),
        .state_q   (state_q)
    );

    always #5 clk = ~clk;

    // NAND latch: low sbar sets, low rbar resets, both high holds.
    always @(sbar, rbar) begin
        if (sbar === 1'b0) lq = 1'b1;
        else if (rbar === 1'b0) lq = 1'b0;
    end
    assign q_in = tie0 ? 1'b0 : lq;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  cyc = 0;
    bit  qh [HIST];
    bit  rh [HIST];
    bit  busy = 0;
    int  tacc = 0;
    bit  tgt  = 0;
    int  d;
    bit  e_ready = 0, e_sbar = 1, e_rbar = 1, e_done = 0, e_err = 0, e_stq = 0;

    // Synchronized Q seen at edge c: latch value two edges earlier, forced
    // to 0 if either synchronizer stage was cleared in between.
    function automatic bit sync_at(input int c);
        if (c < 2) return 1'b0;
        if (rh[c-1] || rh[c-2]) return 1'b0;
        return qh[c-2];
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) begin
            qh[cyc] = q_in;
            rh[cyc] = reset;
        end
        if (reset) begin
            busy = 0; e_ready = 0; e_sbar = 1; e_rbar = 1;
            e_done = 0; e_err = 0; e_stq = 0;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (!busy) begin
                e_sbar = 1;
                e_rbar = 1;
                if (cmd_valid && e_ready) begin
                    busy = 1; tacc = cyc; tgt = cmd_set; e_ready = 0;
                end else begin
                    e_ready = 1;
                end
            end else begin
                d = cyc - tacc;
                e_sbar = !(tgt == 1'b1 && d >= 1 && d <= PULSE_W);
                e_rbar = !(tgt == 1'b0 && d >= 1 && d <= PULSE_W);
                if (d >= PULSE_W + GAP_W + 2) begin
                    if (sync_at(cyc) == tgt) begin
                        e_done = 1; e_stq = tgt; e_ready = 1; busy = 0;
                    end else if (d == PULSE_W + GAP_W + 1 + TIMEOUT) begin
                        e_err = 1; e_ready = 1; busy = 0;
                    end
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    int done_cnt = 0, err_cnt = 0, sbar_lo = 0, rbar_lo = 0;
    int last_done_cyc = -1, last_err_cyc = -1;
    int hi_run = 100;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("sbar", sbar, e_sbar);
            chk("rbar", rbar, e_rbar);
            chk("cmd_ready", cmd_ready, e_ready);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("state_q", state_q, e_stq);
            chk("not_both_low", sbar | rbar, 1);
            if (done && err) chk("done_err_exclusive", 1, 0);
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (err)  begin err_cnt++;  last_err_cyc  = cyc; end
            if (!sbar) sbar_lo++;
            if (!rbar) rbar_lo++;
            if (!sbar || !rbar) begin
                if (hi_run > 0) chk("gap_before_pulse", int'(hi_run >= GAP_W + 1), 1);
                hi_run = 0;
            end else begin
                hi_run++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int acc_cyc = 0;

    task automatic issue(input bit s);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_set   = s;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, s0, r0, issued, n;
        bit nxt;
        reset = 1'b1; cmd_valid = 1'b0; cmd_set = 1'b0;

        // Reset held three edges.
        repeat (3) @(negedge clk);
        chk("rst_sbar", sbar, 1);
        chk("rst_rbar", rbar, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state_q", state_q, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Set command with the latch model connected.
        d0 = done_cnt; e0 = err_cnt; s0 = sbar_lo; r0 = rbar_lo;
        issue(1'b1);
        repeat (12) @(negedge clk);
        chk("set_done_latency", last_done_cyc - acc_cyc, 5);
        chk("set_done_count", done_cnt - d0, 1);
        chk("set_sbar_width", sbar_lo - s0, 2);
        chk("set_rbar_width", rbar_lo - r0, 0);
        chk("set_state_q", state_q, 1);
        chk("set_err_count", err_cnt - e0, 0);

        // Reset command.
        d0 = done_cnt; s0 = sbar_lo; r0 = rbar_lo;
        issue(1'b0);
        repeat (12) @(negedge clk);
        chk("rst_cmd_done_latency", last_done_cyc - acc_cyc, 5);
        chk("rst_cmd_done_count", done_cnt - d0, 1);
        chk("rst_cmd_rbar_width", rbar_lo - r0, 2);
        chk("rst_cmd_sbar_width", sbar_lo - s0, 0);
        chk("rst_cmd_state_q", state_q, 0);

        // Readback stuck at 0: set command must time out.
        tie0 = 1'b1;
        d0 = done_cnt; e0 = err_cnt; s0 = sbar_lo;
        issue(1'b1);
        repeat (20) @(negedge clk);
        chk("to_err_latency", last_err_cyc - acc_cyc, 12);
        chk("to_err_count", err_cnt - e0, 1);
        chk("to_done_count", done_cnt - d0, 0);
        chk("to_sbar_width", sbar_lo - s0, 2);
        chk("to_state_q", state_q, 0);
        tie0 = 1'b0;
        @(negedge clk);

        // cmd_valid held high, 20 alternating commands.
        d0 = done_cnt; e0 = err_cnt;
        cmd_valid = 1'b1; nxt = 1'b1; issued = 0; n = 0;
        while (issued < 20 && n < 400) begin
            if (cmd_ready) begin
                cmd_set = nxt;
                nxt = !nxt;
                issued++;
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_issued", issued, 20);
        repeat (15) @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 20);
        chk("b2b_err_count", err_cnt - e0, 0);
        chk("b2b_state_q", state_q, 0);

        // Reset during the second pulse cycle drops the command.
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b1);
        @(negedge clk);
        chk("mid_sbar_low", sbar, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_sbar", sbar, 1);
        chk("mid_rst_rbar", rbar, 1);
        chk("mid_rst_ready", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", cmd_ready, 1);
        repeat (15) @(negedge clk);
        chk("mid_done_count", done_cnt - d0, 0);
        chk("mid_err_count", err_cnt - e0, 0);
        chk("mid_state_q", state_q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
